// File: rtl/iterative_multdiv_if.sv
// rtl/iterative_multdiv_if.sv - operand/control/result bundle between execute stage and mult/div unit
interface iterative_multdiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/iterative_multdiv.sv
// rtl/iterative_multdiv.sv - iterative signed multiply (radix-2 Booth) / divide (restoring), WIDTH cycles per op
module iterative_multdiv #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    iterative_multdiv_if.slave bus
);
    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    state_t r_state, w_state_next;

    logic [CW-1:0]    r_count;
    logic             r_is_div;
    logic             r_neg;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [2*WIDTH:0] r_prod;
    logic [WIDTH-1:0] r_result;
    logic             r_exception;

    logic w_start;
    logic w_last;
    assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign w_last  = (r_count == LAST);

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    assign w_mag_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign w_mag_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

    // Booth step: the add is done one bit wider so the arithmetic shift keeps the true sign
    // even when the multiplicand is the most negative value.
    logic [WIDTH:0]   w_upper;
    logic [WIDTH:0]   w_mcand_x;
    logic [WIDTH:0]   w_sum;
    logic [2*WIDTH:0] w_prod_next;
    assign w_upper     = {r_prod[2*WIDTH], r_prod[2*WIDTH:WIDTH+1]};
    assign w_mcand_x   = {r_op_a[WIDTH-1], r_op_a};
    assign w_prod_next = {w_sum, r_prod[WIDTH:1]};

    always_comb begin
        w_sum = w_upper;
        case (r_prod[1:0])
            2'b01:   w_sum = w_upper + w_mcand_x;
            2'b10:   w_sum = w_upper - w_mcand_x;
            default: w_sum = w_upper;
        endcase
    end

    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_divisor};
    assign w_rem_next = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};

    // Product bits [2W-1:W-1] must all match for the result to fit in W signed bits.
    logic [WIDTH:0]   w_prod_hi;
    logic             w_mul_exc;
    logic [WIDTH-1:0] w_quo_signed;
    logic [WIDTH-1:0] w_final_result;
    logic             w_final_exc;
    assign w_prod_hi    = w_prod_next[2*WIDTH:WIDTH];
    assign w_mul_exc    = ~((&w_prod_hi) | ~(|w_prod_hi));
    assign w_quo_signed = r_neg ? -w_quo_next : w_quo_next;

    always_comb begin
        w_final_result = w_quo_signed;
        w_final_exc    = 1'b0;
        if (!r_is_div) begin
            w_final_result = w_prod_next[WIDTH:1];
            w_final_exc    = w_mul_exc;
        end else if (r_op_b == '0) begin
            w_final_result = '0;
            w_final_exc    = 1'b1;
        end else if (r_op_a == MIN_NEG && (&r_op_b)) begin
            w_final_result = MIN_NEG;
            w_final_exc    = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = S_BUSY;
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = S_IDLE;
                S_BUSY:  w_state_next = w_last ? S_DONE : S_BUSY;
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy           = 1'b0;
        bus.data_resultRDY = 1'b0;
        case (r_state)
            S_BUSY:  bus.busy = 1'b1;
            S_DONE:  bus.data_resultRDY = 1'b1;
            default: bus.busy = 1'b0;
        endcase
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exception;

    // A start takes priority over an in-flight iteration, which is how restarts abort.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count     <= '0;
            r_is_div    <= 1'b0;
            r_neg       <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_divisor   <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_prod      <= '0;
            r_result    <= '0;
            r_exception <= 1'b0;
        end else if (w_start) begin
            r_count   <= '0;
            r_is_div  <= ~bus.ctrl_MULT;
            r_neg     <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            r_op_a    <= bus.data_operandA;
            r_op_b    <= bus.data_operandB;
            r_divisor <= w_mag_b;
            r_quo     <= w_mag_a;
            r_rem     <= '0;
            r_prod    <= {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
        end else if (r_state == S_BUSY) begin
            r_count <= r_count + 1'b1;
            if (r_is_div) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
            end else begin
                r_prod <= w_prod_next;
            end
            if (w_last) begin
                r_result    <= w_final_result;
                r_exception <= w_final_exc;
            end
        end
    end
endmodule

// File: tb/tb_iterative_multdiv.sv
// tb/tb_iterative_multdiv.sv - directed self-checking bench for iterative_multdiv
module tb_iterative_multdiv;
    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    iterative_multdiv_if #(.WIDTH(32)) bus ();

    iterative_multdiv #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = ~a;
        bus.data_operandB = 32'h1234_5678;
    endtask

    // lat = edges after the start edge at which ready is seen, -1 if never within budget
    task automatic wait_ready(output int lat, output int busy_cyc);
        lat      = -1;
        busy_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) begin
                lat = i;
                break;
            end
            if (bus.busy === 1'b1) busy_cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.ctrl_MULT     = 1'b1;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'd9;
        bus.data_operandB = 32'd9;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (bus.data_result !== 32'd0) begin failures++; $display("FAIL reset result: got %h want 00000000", bus.data_result); end
        checks++; if (bus.data_exception !== 1'b0) begin failures++; $display("FAIL reset exception: got %b want 0", bus.data_exception); end
        checks++; if (bus.data_resultRDY !== 1'b0) begin failures++; $display("FAIL reset ready: got %b want 0", bus.data_resultRDY); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset busy (reset beats start): got %b want 0", bus.busy); end
        bus.ctrl_MULT = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_mult();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [31:0] vr [5];
        logic        ve [5];
        int lat, bc;
        va = '{32'd7,        32'h0001_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        vb = '{32'hFFFF_FFFA, 32'h0001_0000, 32'd1,        32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vr = '{32'hFFFF_FFD6, 32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001};
        ve = '{1'b0,          1'b1,          1'b0,          1'b1,          1'b0};
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, 1'b0, va[i], vb[i]);
            wait_ready(lat, bc);
            checks++; if (lat !== 32) begin failures++; $display("FAIL mult%0d latency: got %0d want 32", i, lat); end
            checks++; if (bc !== 32) begin failures++; $display("FAIL mult%0d busy cycles: got %0d want 32", i, bc); end
            checks++; if (bus.data_result !== vr[i]) begin failures++; $display("FAIL mult%0d result: got %h want %h", i, bus.data_result, vr[i]); end
            checks++; if (bus.data_exception !== ve[i]) begin failures++; $display("FAIL mult%0d exception: got %b want %b", i, bus.data_exception, ve[i]); end
            @(negedge clock);
            checks++; if (bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL mult%0d after-done rdy/busy: got %b%b want 00", i, bus.data_resultRDY, bus.busy); end
        end
    endtask

    task automatic test_div();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [31:0] vr [6];
        logic        ve [6];
        int lat, bc;
        va = '{32'hFFFF_FFF9, 32'd100,       32'd5, 32'h8000_0000, 32'hFFFF_FF9C, 32'h8000_0000};
        vb = '{32'd2,         32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd2};
        vr = '{32'hFFFF_FFFD, 32'hFFFF_FFF2, 32'd0, 32'h8000_0000, 32'h0000_000E, 32'hC000_0000};
        ve = '{1'b0,          1'b0,          1'b1,  1'b1,          1'b0,          1'b0};
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, 1'b1, va[i], vb[i]);
            wait_ready(lat, bc);
            checks++; if (lat !== 32) begin failures++; $display("FAIL div%0d latency: got %0d want 32", i, lat); end
            checks++; if (bus.data_result !== vr[i]) begin failures++; $display("FAIL div%0d result: got %h want %h", i, bus.data_result, vr[i]); end
            checks++; if (bus.data_exception !== ve[i]) begin failures++; $display("FAIL div%0d exception: got %b want %b", i, bus.data_exception, ve[i]); end
            @(negedge clock);
            checks++; if (bus.data_resultRDY !== 1'b0) begin failures++; $display("FAIL div%0d ready width: got %b want 0", i, bus.data_resultRDY); end
        end
    endtask

    task automatic test_both();
        int lat, bc;
        issue(1'b1, 1'b1, 32'd6, 32'd3);
        wait_ready(lat, bc);
        checks++; if (lat !== 32) begin failures++; $display("FAIL both latency: got %0d want 32", lat); end
        checks++; if (bus.data_result !== 32'd18) begin failures++; $display("FAIL both mult-wins result: got %h want 00000012", bus.data_result); end
        checks++; if (bus.data_exception !== 1'b0) begin failures++; $display("FAIL both exception: got %b want 0", bus.data_exception); end
    endtask

    task automatic test_restart();
        int lat, bc, seen;
        seen = 0;
        issue(1'b1, 1'b0, 32'd3, 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) seen++;
        end
        checks++; if (bus.data_result !== 32'd18) begin failures++; $display("FAIL restart held result during op: got %h want 00000012", bus.data_result); end
        issue(1'b0, 1'b1, 32'd20, 32'd4);
        wait_ready(lat, bc);
        checks++; if (seen !== 0) begin failures++; $display("FAIL restart early ready: got %0d want 0", seen); end
        checks++; if (lat !== 32) begin failures++; $display("FAIL restart latency: got %0d want 32", lat); end
        checks++; if (bus.data_result !== 32'd5) begin failures++; $display("FAIL restart result: got %h want 00000005", bus.data_result); end
    endtask

    task automatic test_reset_midop();
        int seen;
        seen = 0;
        issue(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checks++; if (bus.data_result !== 32'd0) begin failures++; $display("FAIL midreset result: got %h want 00000000", bus.data_result); end
        checks++; if (bus.data_exception !== 1'b0) begin failures++; $display("FAIL midreset exception: got %b want 0", bus.data_exception); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset busy: got %b want 0", bus.busy); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midreset ready after abandon: got %0d want 0", seen); end
    endtask

    task automatic test_hold();
        int lat, bc;
        issue(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2);
        wait_ready(lat, bc);
        checks++; if (lat !== 32) begin failures++; $display("FAIL hold latency: got %0d want 32", lat); end
        checks++; if (bus.data_result !== 32'hFFFF_FFFE) begin failures++; $display("FAIL hold result: got %h want fffffffe", bus.data_result); end
        checks++; if (bus.data_exception !== 1'b1) begin failures++; $display("FAIL hold exception: got %b want 1", bus.data_exception); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            bus.data_operandA = $urandom;
            bus.data_operandB = $urandom;
            @(negedge clock);
            checks++;
            if (bus.data_result !== 32'hFFFF_FFFE || bus.data_exception !== 1'b1 || bus.data_resultRDY !== 1'b0) begin
                failures++;
                $display("FAIL hold cycle %0d: got res=%h exc=%b rdy=%b want res=fffffffe exc=1 rdy=0",
                         i, bus.data_result, bus.data_exception, bus.data_resultRDY);
            end
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        test_reset();
        test_mult();
        test_div();
        test_both();
        test_restart();
        test_reset_midop();
        test_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
